// File: rtl/wb_lsu_pkg.sv
// Shared types and constants for the Wishbone load/store unit.
// Holds the FSM state encoding, access-size codes and byte-lane masks.
package lsu_pkg;

  localparam int XLEN      = 32;
  localparam int XLEN_GRAN = 2;
  localparam int NLANES    = XLEN / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  localparam logic [NLANES-1:0] SEL_BYTE = 4'b0001;
  localparam logic [NLANES-1:0] SEL_HALF = 4'b0011;
  localparam logic [NLANES-1:0] SEL_WORD = 4'b1111;

  // Size 3 is never legal; wider accesses must sit on their natural boundary.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [XLEN_GRAN-1:0] off);
    case (size_e'(size))
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/wb_lsu_align.sv
// Lane steering for the LSU: byte-select generation, store-data replication
// and load-data extraction with sign/zero extension.
module wb_lsu_align
  import lsu_pkg::*;
(
  input  logic [XLEN_GRAN-1:0] off_i,
  input  logic [1:0]           size_i,
  input  logic                 unsigned_i,
  input  logic [XLEN-1:0]      wdata_i,
  input  logic [XLEN-1:0]      bus_rdata_i,
  output logic [NLANES-1:0]    sel_o,
  output logic [XLEN-1:0]      wdat_o,
  output logic [XLEN-1:0]      rdata_o
);

  logic [NLANES-1:0] mask;
  logic [XLEN-1:0]   shifted;

  always_comb begin
    mask    = '0;
    wdat_o  = wdata_i;
    rdata_o = '0;
    shifted = bus_rdata_i >> {off_i, 3'b000};
    case (size_e'(size_i))
      SZ_BYTE: begin
        mask    = SEL_BYTE;
        wdat_o  = {NLANES{wdata_i[7:0]}};
        rdata_o = {{(XLEN-8){~unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        mask    = SEL_HALF;
        wdat_o  = {(NLANES/2){wdata_i[15:0]}};
        rdata_o = {{(XLEN-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        mask    = SEL_WORD;
        wdat_o  = wdata_i;
        rdata_o = shifted;
      end
      default: ;
    endcase
    sel_o = mask << off_i;
  end

endmodule

// File: rtl/wb_lsu.sv
// Single-outstanding load/store unit bridging a core request port to a
// Wishbone pipelined master, with alignment checking and an ack timeout.
module wb_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [XLEN-1:0]           req_addr_i,
  input  logic [1:0]                req_size_i,
  input  logic                      req_unsigned_i,
  input  logic [XLEN-1:0]           req_wdata_i,
  output logic                      rsp_valid_o,
  output logic [XLEN-1:0]           rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_misaligned_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [XLEN-XLEN_GRAN-1:0] wb_adr_o,
  output logic [NLANES-1:0]         wb_sel_o,
  output logic [XLEN-1:0]           wb_dat_o,
  input  logic [XLEN-1:0]           wb_dat_i,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i,
  input  logic                      wb_stall_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              mis_q, mis_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic [NLANES-1:0] sel;
  logic [XLEN-1:0]   wdat;
  logic [XLEN-1:0]   ld_data;
  logic              bus_active;

  wb_lsu_align u_align (
    .off_i       (addr_q[XLEN_GRAN-1:0]),
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .wdata_i     (wdata_q),
    .bus_rdata_i (wb_dat_i),
    .sel_o       (sel),
    .wdat_o      (wdat),
    .rdata_o     (ld_data)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          wdata_d = req_wdata_i;
          err_d   = 1'b0;
          rdata_d = '0;
          // Faulting requests never touch the bus.
          if (is_misaligned(req_size_i, req_addr_i[XLEN_GRAN-1:0])) begin
            mis_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            mis_d   = 1'b0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (!wb_stall_i) begin
          cnt_d = '0;
          if (wb_err_i) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (wb_ack_i) begin
            rdata_d = we_q ? '0 : ld_data;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (wb_err_i) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (wb_ack_i) begin
          rdata_d = we_q ? '0 : ld_data;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        err_d   = 1'b0;
        mis_d   = 1'b0;
        rdata_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_active       = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign req_ready_o      = (state_q == ST_IDLE);
  assign rsp_valid_o      = (state_q == ST_RESP);
  assign rsp_err_o        = err_q;
  assign rsp_misaligned_o = mis_q;
  assign rsp_rdata_o      = rdata_q;

  // Bus fields are held at zero outside a cycle so idle and reset look clean.
  assign wb_cyc_o = bus_active;
  assign wb_stb_o = (state_q == ST_REQ);
  assign wb_we_o  = bus_active & we_q;
  assign wb_adr_o = bus_active ? addr_q[XLEN-1:XLEN_GRAN] : '0;
  assign wb_sel_o = bus_active ? sel : '0;
  assign wb_dat_o = bus_active ? wdat : '0;

endmodule
